serial_bus_sched: RTL and testbench
===================================

Name: serial_bus_sched

Overview:
- Sequences and arbitrates the shared 8-bit serial link between the CPU core and the Arduino host.
- Three requesters (PC fetch, MDR store data, MAR address) each present a 16-bit word. The block grants one requester at a time, sends the word as two bytes with a ready handshake, and optionally collects a 16-bit read-back word from the inbound byte stream.
- Drives the bus_pc/bus_mdr/bus_mar select strobes and out_bus that the core currently muxes combinationally.

Parameters:
- DATA_W, 16, requester word width; must be 16 (two bytes); other values unsupported.
- TIMEOUT_CYCLES, 255, wait-state cycle limit; used only with SERIAL_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  3  transfer requests; bit0 PC, bit1 MDR, bit2 MAR
- req_rd  in  3  per-requester flag: transfer expects a 16-bit read-back
- wdata_pc  in  16  PC word to send
- wdata_mdr  in  16  MDR word to send
- wdata_mar  in  16  MAR word to send
- ard_receive_ready  in  1  host accepts the out_bus byte this cycle
- ard_data_ready  in  1  host drives a valid in_bus byte this cycle
- in_bus  in  8  inbound byte
- gnt  out  3  one-hot owner of the link, same bit order as req
- done  out  3  one-cycle completion pulse, same bit order
- rdata  out  16  assembled read-back word; valid while done is high for a read transfer
- out_bus  out  8  outbound byte
- bus_pc, bus_mdr, bus_mar  out  1 each  select strobes; high only while that requester's byte is on out_bus
- busy  out  1  high in any state other than IDLE
- error  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): state IDLE, rr_ptr=MAR (so PC wins first). All outputs 0, rdata=0, error=0. Applying reset mid-transfer aborts immediately; no done pulse is produced.
- States: IDLE, SEND_LO, SEND_HI, RECV_LO, RECV_HI, DONE.
- IDLE → SEND_LO when req≠0.
  - Grant is round-robin: search starts at rr_ptr+1 (wrapping MAR→PC). rr_ptr is updated to the winner.
  - The winner's word and req_rd are latched on this edge; gnt is registered.
- SEND_LO: out_bus=word[7:0], the matching bus_x strobe is high. Hold until ard_receive_ready=1, then → SEND_HI.
- SEND_HI: out_bus=word[15:8]. On ard_receive_ready=1: → RECV_LO if the latched req_rd=1, else → DONE.
- RECV_LO: on ard_data_ready=1, capture in_bus into rdata[7:0], → RECV_HI.
- RECV_HI: on ard_data_ready=1, capture in_bus into rdata[15:8], → DONE.
- DONE: done[owner]=1 for one cycle, gnt still held, → IDLE. gnt clears on entry to IDLE.
- Outside the SEND states: out_bus=0 and all strobes are 0.
- Latency with an always-ready host, req seen in IDLE at cycle N:
  - Write: SEND_LO N+1, SEND_HI N+2, DONE N+3, IDLE N+4.
  - Read: DONE at N+5.
  - Earliest next grant: SEND_LO at N+5 (write case).
- Request handling:
  - req changes after the grant are ignored until DONE.
  - The requester must hold req until done, and must drop it in the done cycle or it is re-arbitrated.
- Protocol errors:
  - ard_data_ready=1 during SEND_LO/SEND_HI sets error (sticky until reset); the byte is ignored.
  - ard_data_ready in IDLE/DONE is ignored with no error.
- ard_receive_ready outside the SEND states is ignored.
- Simultaneous requests: exactly one gnt bit is set. The others wait without starving: each waits at most 2 transfers.

Optional Feature:
- Macro: SERIAL_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on every state change and increments each cycle spent in SEND_*/RECV_* without the relevant ready signal.
  - When it reaches TIMEOUT_CYCLES: set error, → IDLE, drop gnt, no done pulse. rr_ptr keeps the aborted owner.
- Undefined: no counter; the FSM waits indefinitely in any wait state.

Test Plan:
- Reset, then req=001, req_rd=000, wdata_pc=16'hA55A, ard_receive_ready=1 → out_bus 8'h5A with bus_pc at N+1, 8'hA5 at N+2, done=001 at N+3, busy low at N+4.
- req=010, req_rd=010, wdata_mdr=16'h1234; in_bus 8'hCD then 8'hAB with ard_data_ready → bytes 8'h34, 8'h12 sent; done=010 with rdata=16'hABCD.
- req=111 held, each requester dropping its req bit on its done pulse → grant order PC, MDR, MAR; gnt always one-hot.
- ard_receive_ready low 10 cycles in SEND_LO → out_bus stays 8'h5A, strobe held; advance occurs one cycle after ready rises.
- ard_data_ready=1 during SEND_HI → error=1, stays 1 after transfer completes, cleared only by rst=0.
- With SERIAL_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted → error set after 4 wait cycles, IDLE, no done. Mid-transfer rst=0 → all outputs 0 asynchronously.

Source files
------------

// File: rtl/serial_bus_sched.sv
// rtl/serial_bus_sched.sv - round-robin scheduler for the shared 8-bit host serial link
// Optional macro SERIAL_BUS_TIMEOUT_EN adds a wait-state timeout that aborts the transfer.
module serial_bus_sched #(
   parameter int DATA_W = 16
`ifdef SERIAL_BUS_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [2:0]        req_rd,
   input  logic [DATA_W-1:0] wdata_pc,
   input  logic [DATA_W-1:0] wdata_mdr,
   input  logic [DATA_W-1:0] wdata_mar,
   input  logic              ard_receive_ready,
   input  logic              ard_data_ready,
   input  logic [7:0]        in_bus,
   output logic [2:0]        gnt,
   output logic [2:0]        done,
   output logic [15:0]       rdata,
   output logic [7:0]        out_bus,
   output logic              bus_pc,
   output logic              bus_mdr,
   output logic              bus_mar,
   output logic              busy,
   output logic              error
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SEND_LO = 3'd1;
   localparam logic [2:0] SEND_HI = 3'd2;
   localparam logic [2:0] RECV_LO = 3'd3;
   localparam logic [2:0] RECV_HI = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]        r_state;
   logic [1:0]        r_rr;
   logic [2:0]        r_gnt;
   logic [DATA_W-1:0] r_word;
   logic              r_rd;
   logic [15:0]       r_rdata;
   logic              r_error;

   logic [1:0]        w_c0, w_c1, w_c2, w_win;
   logic [DATA_W-1:0] w_word;
   logic              w_send;

   // Candidates in priority order, starting just after the last winner (index 2 wraps to 0).
   always_comb begin
      w_c0  = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
      w_c1  = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
      w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
      w_win = w_c2;
      if (req[w_c1]) w_win = w_c1;
      if (req[w_c0]) w_win = w_c0;
      case (w_win)
         2'd0:    w_word = wdata_pc;
         2'd1:    w_word = wdata_mdr;
         default: w_word = wdata_mar;
      endcase
   end

`ifdef SERIAL_BUS_TIMEOUT_EN
   logic [7:0] r_wait_cnt;
   logic       w_wait;
   assign w_wait = ((r_state == SEND_LO || r_state == SEND_HI) && !ard_receive_ready) ||
                   ((r_state == RECV_LO || r_state == RECV_HI) && !ard_data_ready);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_rr    <= 2'd2;
         r_gnt   <= 3'b000;
         r_word  <= '0;
         r_rd    <= 1'b0;
         r_rdata <= 16'h0000;
         r_error <= 1'b0;
`ifdef SERIAL_BUS_TIMEOUT_EN
         r_wait_cnt <= 8'd0;
`endif
      end else begin
         if ((r_state == SEND_LO || r_state == SEND_HI) && ard_data_ready)
            r_error <= 1'b1;
         case (r_state)
            IDLE: if (|req) begin
               r_state <= SEND_LO;
               r_gnt   <= 3'b001 << w_win;
               r_rr    <= w_win;
               r_word  <= w_word;
               r_rd    <= req_rd[w_win];
            end
            SEND_LO: if (ard_receive_ready) r_state <= SEND_HI;
            SEND_HI: if (ard_receive_ready) r_state <= r_rd ? RECV_LO : DONE;
            RECV_LO: if (ard_data_ready) begin
               r_rdata[7:0] <= in_bus;
               r_state      <= RECV_HI;
            end
            RECV_HI: if (ard_data_ready) begin
               r_rdata[15:8] <= in_bus;
               r_state       <= DONE;
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= 3'b000;
            end
         endcase
`ifdef SERIAL_BUS_TIMEOUT_EN
         // Abort overrides the case above; the owner stays in rr_ptr.
         if (w_wait) begin
            if (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
               r_state    <= IDLE;
               r_gnt      <= 3'b000;
               r_error    <= 1'b1;
               r_wait_cnt <= 8'd0;
            end else begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
            end
         end else begin
            r_wait_cnt <= 8'd0;
         end
`endif
      end
   end

   assign w_send  = (r_state == SEND_LO) || (r_state == SEND_HI);
   assign out_bus = (r_state == SEND_LO) ? r_word[7:0] :
                    (r_state == SEND_HI) ? r_word[15:8] : 8'h00;
   assign bus_pc  = w_send & r_gnt[0];
   assign bus_mdr = w_send & r_gnt[1];
   assign bus_mar = w_send & r_gnt[2];
   assign gnt     = r_gnt;
   assign done    = (r_state == DONE) ? r_gnt : 3'b000;
   assign rdata   = r_rdata;
   assign busy    = (r_state != IDLE);
   assign error   = r_error;

endmodule

// File: tb/tb_serial_bus_sched.sv
// tb/tb_serial_bus_sched.sv - directed self-checking bench for serial_bus_sched
module tb_serial_bus_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  req = 3'b000;
   logic [2:0]  req_rd = 3'b000;
   logic [15:0] wdata_pc = 16'h0000;
   logic [15:0] wdata_mdr = 16'h0000;
   logic [15:0] wdata_mar = 16'h0000;
   logic        ard_receive_ready = 1'b0;
   logic        ard_data_ready = 1'b0;
   logic [7:0]  in_bus = 8'h00;
   logic [2:0]  gnt, done;
   logic [15:0] rdata;
   logic [7:0]  out_bus;
   logic        bus_pc, bus_mdr, bus_mar, busy, error;

   int checks = 0;
   int errors = 0;

   serial_bus_sched dut (
      .clk(clk), .rst(rst), .req(req), .req_rd(req_rd),
      .wdata_pc(wdata_pc), .wdata_mdr(wdata_mdr), .wdata_mar(wdata_mar),
      .ard_receive_ready(ard_receive_ready), .ard_data_ready(ard_data_ready),
      .in_bus(in_bus), .gnt(gnt), .done(done), .rdata(rdata), .out_bus(out_bus),
      .bus_pc(bus_pc), .bus_mdr(bus_mdr), .bus_mar(bus_mar), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({gnt, done, rdata, out_bus, bus_pc, bus_mdr, bus_mar, busy, error} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs got gnt=%b done=%b rdata=%h out=%h strobes=%b%b%b busy=%b err=%b exp all zero",
                  gnt, done, rdata, out_bus, bus_pc, bus_mdr, bus_mar, busy, error);
      end
      rst = 1'b1;
   endtask

   task automatic test_write();
      req = 3'b001; req_rd = 3'b000; wdata_pc = 16'hA55A; ard_receive_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_bus, bus_pc, gnt} !== {8'h5A, 1'b1, 3'b001}) begin
         errors++; $display("FAIL write_lo got out=%h pc=%b gnt=%b exp 5a 1 001", out_bus, bus_pc, gnt);
      end
      @(negedge clk);
      checks++;
      if ({out_bus, bus_pc} !== {8'hA5, 1'b1}) begin
         errors++; $display("FAIL write_hi got out=%h pc=%b exp a5 1", out_bus, bus_pc);
      end
      @(negedge clk);
      checks++;
      if ({done, gnt, out_bus, bus_pc} !== {3'b001, 3'b001, 8'h00, 1'b0}) begin
         errors++; $display("FAIL write_done got done=%b gnt=%b out=%h pc=%b exp 001 001 00 0", done, gnt, out_bus, bus_pc);
      end
      req = 3'b000;
      @(negedge clk);
      checks++;
      if ({busy, gnt, done} !== 7'b0) begin
         errors++; $display("FAIL write_idle got busy=%b gnt=%b done=%b exp 0 000 000", busy, gnt, done);
      end
   endtask

   task automatic test_read();
      req = 3'b010; req_rd = 3'b010; wdata_mdr = 16'h1234; ard_receive_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_bus, bus_mdr, bus_pc, gnt} !== {8'h34, 1'b1, 1'b0, 3'b010}) begin
         errors++; $display("FAIL read_lo got out=%h mdr=%b pc=%b gnt=%b exp 34 1 0 010", out_bus, bus_mdr, bus_pc, gnt);
      end
      @(negedge clk);
      checks++;
      if ({out_bus, bus_mdr} !== {8'h12, 1'b1}) begin
         errors++; $display("FAIL read_hi got out=%h mdr=%b exp 12 1", out_bus, bus_mdr);
      end
      @(negedge clk);
      checks++;
      if ({busy, out_bus, bus_mdr, done} !== {1'b1, 8'h00, 1'b0, 3'b000}) begin
         errors++; $display("FAIL read_recv got busy=%b out=%h mdr=%b done=%b exp 1 00 0 000", busy, out_bus, bus_mdr, done);
      end
      in_bus = 8'hCD; ard_data_ready = 1'b1;
      @(negedge clk);
      in_bus = 8'hAB;
      @(negedge clk);
      checks++;
      if ({done, rdata, error} !== {3'b010, 16'hABCD, 1'b0}) begin
         errors++; $display("FAIL read_done got done=%b rdata=%h err=%b exp 010 abcd 0", done, rdata, error);
      end
      req = 3'b000; req_rd = 3'b000; ard_data_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_order [3];
      exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
      apply_reset();
      req = 3'b111; req_rd = 3'b000; ard_receive_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bit seen = 1'b0;
         for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (gnt !== 3'b000 && gnt !== 3'b001 && gnt !== 3'b010 && gnt !== 3'b100) begin
               checks++; errors++; $display("FAIL rr_onehot got gnt=%b exp one-hot", gnt);
            end
            if (done !== 3'b000) begin
               seen = 1'b1;
               checks++;
               if (done !== exp_order[k]) begin
                  errors++; $display("FAIL rr_order got done=%b exp %b", done, exp_order[k]);
               end
               req = req & ~done;
            end
         end
         if (!seen) begin
            checks++; errors++; $display("FAIL rr_timeout got no done exp %b", exp_order[k]);
         end
      end
      req = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_stall();
      req = 3'b001; wdata_pc = 16'hA55A; ard_receive_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({out_bus, bus_pc} !== {8'h5A, 1'b1}) begin
            errors++; $display("FAIL stall_hold cycle %0d got out=%h pc=%b exp 5a 1", i, out_bus, bus_pc);
         end
      end
      ard_receive_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_bus !== 8'hA5) begin
         errors++; $display("FAIL stall_advance got out=%h exp a5", out_bus);
      end
      @(negedge clk);
      req = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_protocol_error();
      req = 3'b001; ard_receive_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (error !== 1'b0) begin
         errors++; $display("FAIL err_before got err=%b exp 0", error);
      end
      ard_data_ready = 1'b1; in_bus = 8'hFF;
      @(negedge clk);
      checks++;
      if ({error, done} !== {1'b1, 3'b001}) begin
         errors++; $display("FAIL err_set got err=%b done=%b exp 1 001", error, done);
      end
      req = 3'b000; ard_data_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({error, busy} !== 2'b10) begin
         errors++; $display("FAIL err_sticky got err=%b busy=%b exp 1 0", error, busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (error !== 1'b0) begin
         errors++; $display("FAIL err_clear got err=%b exp 0", error);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      req = 3'b001; req_rd = 3'b000; wdata_pc = 16'hA55A; ard_receive_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 3'b001) begin
         errors++; $display("FAIL b2b_done got done=%b exp 001", done);
      end
      @(negedge clk);
      checks++;
      if ({busy, gnt} !== 4'b0000) begin
         errors++; $display("FAIL b2b_idle got busy=%b gnt=%b exp 0 000", busy, gnt);
      end
      @(negedge clk);
      checks++;
      if ({out_bus, bus_pc, gnt} !== {8'h5A, 1'b1, 3'b001}) begin
         errors++; $display("FAIL b2b_regrant got out=%h pc=%b gnt=%b exp 5a 1 001", out_bus, bus_pc, gnt);
      end
      req = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_async_abort();
      req = 3'b010; wdata_mdr = 16'h1234; ard_receive_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, bus_mdr, out_bus} !== {1'b1, 1'b1, 8'h34}) begin
         errors++; $display("FAIL abort_pre got busy=%b mdr=%b out=%h exp 1 1 34", busy, bus_mdr, out_bus);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({gnt, done, out_bus, bus_pc, bus_mdr, bus_mar, busy, error} !== 20'h0) begin
         errors++; $display("FAIL abort_async got gnt=%b done=%b out=%h mdr=%b busy=%b exp all zero",
                            gnt, done, out_bus, bus_mdr, busy);
      end
      req = 3'b000;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({done, busy} !== 4'b0) begin
            errors++; $display("FAIL abort_nodone got done=%b busy=%b exp 000 0", done, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_stall();
      test_protocol_error();
      test_back_to_back();
      test_async_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end
endmodule
